// File: rtl/eth_frame_pattern_bank.sv
// eth_frame_pattern_bank: per-channel pattern RAM with a handshaked port A and a free-running read port B.
// Define ETH_FRAME_PATTERN_CLEAR_EN to compile in the zero-fill clear sweep.
module eth_frame_pattern_bank #(
    parameter int C_AXI_WIDTH    = 32,
    parameter int C_ADDR_WIDTH   = 11,
    parameter int C_NUM_CHANNELS = 2,
    localparam int CW    = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1,
    localparam int NB    = C_AXI_WIDTH / 8,
    localparam int DEPTH = 1 << C_ADDR_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   mem_pa_req,
    input  logic                                   mem_pa_we,
    output logic                                   mem_pa_ack,
    output logic                                   mem_pa_err,
    input  logic [CW-1:0]                          mem_pa_chan,
    input  logic [C_ADDR_WIDTH-1:0]                mem_pa_addr,
    input  logic [C_AXI_WIDTH-1:0]                 mem_pa_wdata,
    input  logic [NB-1:0]                          mem_pa_wstrb,
    output logic [C_AXI_WIDTH-1:0]                 mem_pa_rdata,
    input  logic [C_NUM_CHANNELS*C_ADDR_WIDTH-1:0] mem_pb_addr,
    output logic [C_NUM_CHANNELS*C_AXI_WIDTH-1:0]  mem_pb_rdata,
    input  logic                                   mem_clear,
    output logic                                   mem_busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t                  state;
    logic                    rst_ok;
    logic [CW-1:0]           ch_q;
    logic [CW-1:0]           ch_i;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic                    we_q;
    logic [C_AXI_WIDTH-1:0]  wdata_q;
    logic [NB-1:0]           wstrb_q;
    logic                    ch_bad;
    logic                    blocked;
    logic [C_AXI_WIDTH-1:0]  mem [C_NUM_CHANNELS][DEPTH];

    assign ch_bad = {1'b0, ch_q} >= (CW+1)'(C_NUM_CHANNELS);
    assign ch_i   = ch_bad ? '0 : ch_q;

    // Release is synchronised; the FSM accepts requests from the second edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_ok <= 1'b0;
        else        rst_ok <= 1'b1;

`ifdef ETH_FRAME_PATTERN_CLEAR_EN
    logic                    pending;
    logic                    sweep_on;
    logic [C_ADDR_WIDTH-1:0] cnt;
    logic                    start;

    assign start    = rst_ok && state == IDLE && !sweep_on && (pending || mem_clear);
    assign blocked  = sweep_on || pending || mem_clear;
    assign mem_busy = sweep_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            sweep_on <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            pending  <= 1'b0;
            sweep_on <= 1'b1;
            cnt      <= '0;
        end else if (sweep_on) begin
            cnt <= cnt + 1'b1;
            if (&cnt) sweep_on <= 1'b0;
        end else if (mem_clear) begin
            pending <= 1'b1;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = mem_clear;
    assign blocked      = 1'b0;
    assign mem_busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_pa_ack   <= 1'b0;
            mem_pa_err   <= 1'b0;
            mem_pa_rdata <= '0;
            ch_q         <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            case (state)
                IDLE: if (rst_ok && mem_pa_req && !mem_pa_ack && !blocked) begin
                    state   <= ACCESS;
                    ch_q    <= mem_pa_chan;
                    addr_q  <= mem_pa_addr;
                    we_q    <= mem_pa_we;
                    wdata_q <= mem_pa_wdata;
                    wstrb_q <= mem_pa_wstrb;
                end
                ACCESS: begin
                    state      <= ACK;
                    mem_pa_ack <= 1'b1;
                    mem_pa_err <= ch_bad;
                    if (ch_bad) mem_pa_rdata <= '0;
                    else if (!we_q) mem_pa_rdata <= mem[ch_i][addr_q];
                end
                ACK: if (!mem_pa_req) begin
                    state      <= IDLE;
                    mem_pa_ack <= 1'b0;
                    mem_pa_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write only lands on the ACCESS->ACK edge.
    always_ff @(posedge clk) begin
`ifdef ETH_FRAME_PATTERN_CLEAR_EN
        if (sweep_on)
            for (int n = 0; n < C_NUM_CHANNELS; n++) mem[n][cnt] <= '0;
`endif
        if (state == ACCESS && we_q && !ch_bad)
            for (int b = 0; b < NB; b++)
                if (wstrb_q[b]) mem[ch_i][addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mem_pb_rdata <= '0;
        else
            for (int n = 0; n < C_NUM_CHANNELS; n++)
                mem_pb_rdata[n*C_AXI_WIDTH +: C_AXI_WIDTH] <= mem[n][mem_pb_addr[n*C_ADDR_WIDTH +: C_ADDR_WIDTH]];
endmodule

// File: tb/tb_eth_frame_pattern_bank.sv
// tb_eth_frame_pattern_bank: directed checks of port A handshake, port B read-first, reset and clear sweep.
module tb_eth_frame_pattern_bank;
    localparam int W = 32, A = 5, N = 3, CW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mem_pa_req, mem_pa_we, mem_pa_ack, mem_pa_err;
    logic [CW-1:0]  mem_pa_chan;
    logic [A-1:0]   mem_pa_addr;
    logic [W-1:0]   mem_pa_wdata, mem_pa_rdata;
    logic [3:0]     mem_pa_wstrb;
    logic [N*A-1:0] mem_pb_addr;
    logic [N*W-1:0] mem_pb_rdata;
    logic           mem_clear, mem_busy;

    int passed = 0, total = 0;
    logic [W-1:0] rd;
    logic         er;
    int           lat, nb;
    logic         ok;

    eth_frame_pattern_bank #(.C_AXI_WIDTH(W), .C_ADDR_WIDTH(A), .C_NUM_CHANNELS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_pa_req(mem_pa_req), .mem_pa_we(mem_pa_we), .mem_pa_ack(mem_pa_ack), .mem_pa_err(mem_pa_err),
        .mem_pa_chan(mem_pa_chan), .mem_pa_addr(mem_pa_addr), .mem_pa_wdata(mem_pa_wdata),
        .mem_pa_wstrb(mem_pa_wstrb), .mem_pa_rdata(mem_pa_rdata),
        .mem_pb_addr(mem_pb_addr), .mem_pb_rdata(mem_pb_rdata),
        .mem_clear(mem_clear), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin passed++; end
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic access(input logic [1:0] ch, input logic [A-1:0] a, input logic we, input logic [W-1:0] d,
                          input logic [3:0] s, output logic [W-1:0] r, output logic e, output int l);
        mem_pa_chan = ch; mem_pa_addr = a; mem_pa_we = we; mem_pa_wdata = d; mem_pa_wstrb = s;
        mem_pa_req = 1'b1;
        l = 0;
        do begin step(); l++; end while (!mem_pa_ack && l < 100);
        chk("ack_seen", mem_pa_ack, 1);
        r = mem_pa_rdata; e = mem_pa_err;
        mem_pa_req = 1'b0;
        step();
        chk("ack_drop", mem_pa_ack, 0);
    endtask

    initial begin
        rst_n = 1'b0; mem_pa_req = 0; mem_pa_we = 0; mem_pa_chan = 0; mem_pa_addr = 0;
        mem_pa_wdata = 0; mem_pa_wstrb = 0; mem_pb_addr = 0; mem_clear = 0;
        repeat (3) step();
        chk("rst_ack", mem_pa_ack, 0);
        chk("rst_err", mem_pa_err, 0);
        chk("rst_rdata", mem_pa_rdata, 0);
        chk("rst_pb", mem_pb_rdata, 0);
        chk("rst_busy", mem_busy, 0);

        // request pending at release: accepted on 2nd edge, ack after 3rd
        rst_n = 1'b1;
        access(1, 5'h05, 1, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("sync_lat", lat, 3);
        chk("wr_err", er, 0);
        access(1, 5'h05, 0, 0, 0, rd, er, lat);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", er, 0);

        access(0, 5'h07, 1, 32'h11223344, 4'hF, rd, er, lat);
        chk("wr_rdata_hold", rd, 32'hDEADBEEF);
        access(0, 5'h07, 1, 32'hAAAAAAAA, 4'h2, rd, er, lat);
        access(0, 5'h07, 0, 0, 0, rd, er, lat);
        chk("strb_merge", rd, 32'h1122AA44);

        access(0, 5'h05, 1, 32'h0A0A0A0A, 4'hF, rd, er, lat);
        access(2, 5'h05, 1, 32'h0C0C0C0C, 4'hF, rd, er, lat);
        access(3, 5'h05, 1, 32'h00000001, 4'hF, rd, er, lat);
        chk("bad_err", er, 1);
        chk("bad_rdata", rd, 0);
        chk("bad_lat", lat, 2);
        access(0, 5'h05, 0, 0, 0, rd, er, lat);
        chk("bad_keep0", rd, 32'h0A0A0A0A);
        chk("err_clear", er, 0);
        access(1, 5'h05, 0, 0, 0, rd, er, lat);
        chk("bad_keep1", rd, 32'hDEADBEEF);
        access(2, 5'h05, 0, 0, 0, rd, er, lat);
        chk("bad_keep2", rd, 32'h0C0C0C0C);

        access(2, 5'h1F, 1, 32'hCAFEF00D, 4'hF, rd, er, lat);
        access(2, 5'h00, 1, 32'h12345678, 4'hF, rd, er, lat);
        access(2, 5'h1F, 0, 0, 0, rd, er, lat);
        chk("addr_top", rd, 32'hCAFEF00D);
        access(2, 5'h00, 0, 0, 0, rd, er, lat);
        chk("addr_zero", rd, 32'h12345678);

        // read-first collision on ch0 addr 0x10
        access(0, 5'h10, 1, 32'h0, 4'hF, rd, er, lat);
        mem_pb_addr = {5'h1F, 5'h05, 5'h10};
        mem_pa_chan = 0; mem_pa_addr = 5'h10; mem_pa_we = 1; mem_pa_wdata = 32'h55; mem_pa_wstrb = 4'hF;
        mem_pa_req = 1'b1;
        step();
        step();
        chk("coll_ack", mem_pa_ack, 1);
        chk("coll_old", mem_pb_rdata[31:0], 0);
        mem_pa_req = 1'b0;
        step();
        chk("coll_new", mem_pb_rdata[31:0], 32'h55);
        chk("pb_ch1", mem_pb_rdata[63:32], 32'hDEADBEEF);
        chk("pb_ch2", mem_pb_rdata[95:64], 32'hCAFEF00D);

`ifdef ETH_FRAME_PATTERN_CLEAR_EN
        mem_pa_chan = 1; mem_pa_addr = 5'h05; mem_pa_we = 0; mem_pa_req = 1'b1;
        step();
        step();
        chk("clr_in_ack", mem_pa_ack, 1);
        mem_clear = 1'b1; mem_pa_req = 1'b0;
        step();
        mem_clear = 1'b0;
        chk("clr_pending_busy", mem_busy, 0);
        mem_pa_chan = 0; mem_pa_addr = 5'h07; mem_pa_req = 1'b1;
        lat = 0; nb = 0; ok = 1'b1;
        do begin
            step(); lat++;
            if (mem_busy) nb++;
            if (mem_busy && mem_pa_ack) ok = 1'b0;
            mem_clear = (lat == 10);
        end while (!mem_pa_ack && lat < 200);
        mem_clear = 1'b0;
        chk("clr_busy_cycles", nb, 32);
        chk("clr_req_lat", lat, 35);
        chk("clr_no_overlap", ok, 1);
        chk("clr_rdata", mem_pa_rdata, 0);
        mem_pa_req = 1'b0;
        step();
        ok = 1'b1;
        for (int a = 0; a < 32; a++) begin
            mem_pb_addr = {3{5'(a)}};
            step();
            if (mem_pb_rdata !== '0) ok = 1'b0;
        end
        chk("clr_all_zero", ok, 1);

        access(1, 5'h05, 1, 32'h5A5A5A5A, 4'hF, rd, er, lat);
        mem_pa_chan = 1; mem_pa_addr = 5'h05; mem_pa_we = 0; mem_pa_req = 1'b1; mem_clear = 1'b1;
        lat = 0;
        do begin step(); lat++; mem_clear = 1'b0; end while (!mem_pa_ack && lat < 200);
        chk("clr_req_same_lat", lat, 35);
        chk("clr_req_same_rd", mem_pa_rdata, 0);
        mem_pa_req = 1'b0;
        step();
`else
        mem_clear = 1'b1;
        step();
        mem_clear = 1'b0;
        nb = 0;
        repeat (5) begin step(); if (mem_busy) nb++; end
        chk("noclr_busy", nb, 0);
        access(1, 5'h05, 0, 0, 0, rd, er, lat);
        chk("noclr_keep", rd, 32'hDEADBEEF);
`endif

        access(1, 5'h09, 1, 32'h01010101, 4'hF, rd, er, lat);
        access(1, 5'h09, 0, 0, 0, rd, er, lat);
        mem_pb_addr = {5'h00, 5'h09, 5'h00};
        mem_pa_chan = 1; mem_pa_addr = 5'h09; mem_pa_we = 1; mem_pa_wdata = 32'h99999999; mem_pa_wstrb = 4'hF;
        mem_pa_req = 1'b1;
        step();
        chk("pre_rst_pb", mem_pb_rdata[63:32], 32'h01010101);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", mem_pa_ack, 0);
        chk("arst_rdata", mem_pa_rdata, 0);
        chk("arst_pb", mem_pb_rdata, 0);
        chk("arst_busy", mem_busy, 0);
        nb = 0;
        repeat (3) begin step(); if (mem_pa_ack) nb++; end
        chk("arst_no_ack", nb, 0);
        mem_pa_req = 1'b0;
        rst_n = 1'b1;
        access(1, 5'h09, 0, 0, 0, rd, er, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 32'h01010101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
